load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, cycles spent in REQ+WAIT before abort with error (1..1023).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  execute stage presents a memory access.
REQ-005 Port: req_ready  output  1  unit idle, accepts request this cycle.
REQ-006 Port: mren  input  2  decoded load size (00 none, 01 byte, 10 half, 11 word).
REQ-007 Port: mwen  input  2  decoded store size, same encoding as mren.
REQ-008 Port: addr  input  32  byte address from ALU.
REQ-009 Port: wdata  input  32  store data (rs2).
REQ-010 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port: resp_rdata  output  32  sign-extended load result; 0 for stores, no-ops, errors.
REQ-012 Port: resp_err  output  1  misaligned, conflicting or timed-out access; valid with resp_valid.
REQ-013 Port: mem_req_valid  output  1  memory request.
REQ-014 Port: mem_req_ready  input  1  memory accepts request.
REQ-015 Port: mem_addr  output  32  word address (addr with [1:0]=00).
REQ-016 Port: mem_wen  output  1  1 = write, 0 = read.
REQ-017 Port: mem_wdata  output  32  lane-replicated store data.
REQ-018 Port: mem_wstrb  output  4  byte-lane write strobes; 0000 on reads.
REQ-019 Port: mem_rvalid  input  1  read data returned.
REQ-020 Port: mem_rdata  input  32  read word.

Function
REQ-021 FSM states IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE, req_valid=1: latch mren, mwen, addr, wdata; inputs ignored in all other states.
REQ-023 IDLE accept, mren=mwen=00 -> RESP, err=0, rdata=0, no memory request.
REQ-024 IDLE accept, mren!=00 and mwen!=00 -> RESP, err=1, no memory request.
REQ-025 IDLE accept, misaligned (half with addr[0]=1; word with addr[1:0]!=00) -> RESP, err=1, no memory request.
REQ-026 Otherwise IDLE -> REQ; timeout counter cleared to 0.
REQ-027 REQ: mem_req_valid=1; mem_addr, mem_wen, mem_wdata, mem_wstrb held stable until mem_req_ready=1.
REQ-028 REQ handshake, write -> RESP, err=0; read -> WAIT.
REQ-029 WAIT: mem_rvalid=1 captures mem_rdata -> RESP, err=0; mem_rvalid in any other state ignored.
REQ-030 Timeout counter increments each cycle in REQ/WAIT; reaching MEM_TIMEOUT without completion -> RESP, err=1, rdata=0; timeout takes priority over handshake/rvalid in the same cycle.
REQ-031 RESP: resp_valid=1 exactly one cycle, resp_rdata/resp_err registered; next state IDLE; no backpressure.
REQ-032 Strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-033 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-034 Load extract: byte lane addr[1:0] sign-extended from bit 7; half lane addr[1] sign-extended from bit 15; word unchanged.
REQ-035 Latency, no stall: store accept->resp_valid 2 cycles; load with rvalid in first WAIT cycle 3 cycles; no-op/error 1 cycle.
REQ-036 resp_valid=0, mem_req_valid=0 outside RESP/REQ respectively.

Reset
REQ-037 rst_n=0 forces IDLE immediately, asynchronously, including mid-REQ/WAIT; pending transaction abandoned, no response issued.
REQ-038 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req_valid=0, mem_addr=0, mem_wen=0, mem_wdata=0, mem_wstrb=0, counter=0.
REQ-039 Late mem_rvalid after reset arrives in IDLE and is ignored.

Verification
REQ-040 LB addr=0x8000_0003, mem_rdata=0x80xx_xxxx, ready/rvalid immediate -> mem_addr=0x8000_0000, resp_rdata=0xFFFF_FF80, resp_valid 3 cycles after accept.
REQ-041 SH addr=0x102, wdata=0x1234_ABCD -> mem_wstrb=1100, mem_wdata=0xABCD_ABCD, mem_wen=1, resp_valid 2 cycles after accept, err=0.
REQ-042 LW addr=0x101 -> no mem_req_valid, resp_valid next cycle, resp_err=1, resp_rdata=0.
REQ-043 mem_req_ready held 0, MEM_TIMEOUT=4 -> mem_req_valid and outputs stable 4 cycles, then resp_err=1, back to IDLE.
REQ-044 rst_n pulled low in WAIT, then mem_rvalid=1 after release -> no resp_valid, req_ready=1, next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage access into a single memory
// transaction with alignment checks, lane steering, sign extension and timeout.
module load_store_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  mren,
  input  logic [1:0]  mwen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | ready for a new access
  // REQ   | memory request presented, waiting for mem_req_ready
  // WAIT  | read issued, waiting for mem_rvalid
  // RESP  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [9:0] CNT_LAST = 10'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  acc_size;
  logic        misaligned;
  logic        timeout;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  assign acc_size   = (mren != 2'b00) ? mren : mwen;
  assign misaligned = ((acc_size == 2'b10) && addr[0]) ||
                      ((acc_size == 2'b11) && (addr[1:0] != 2'b00));
  assign timeout    = (cnt_q == CNT_LAST);

  assign rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    rd_ext = mem_rdata;
    case (size_q)
      2'b01:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      2'b10:   rd_ext = {{16{rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    lane_d      = lane_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = 32'h0;
          if (mren == 2'b00 && mwen == 2'b00) begin
            state_d = RESP;
            err_d   = 1'b0;
          end else if ((mren != 2'b00 && mwen != 2'b00) || misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d    = REQ;
            cnt_d      = 10'd0;
            size_d     = acc_size;
            lane_d     = addr[1:0];
            mem_addr_d = {addr[31:2], 2'b00};
            mem_wen_d  = (mwen != 2'b00);
            mem_wstrb_d = 4'b0000;
            mem_wdata_d = 32'h0;
            if (mwen != 2'b00) begin
              case (mwen)
                2'b01: begin
                  mem_wstrb_d = 4'b0001 << addr[1:0];
                  mem_wdata_d = {4{wdata[7:0]}};
                end
                2'b10: begin
                  mem_wstrb_d = 4'b0011 << addr[1:0];
                  mem_wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                  mem_wstrb_d = 4'b1111;
                  mem_wdata_d = wdata;
                end
              endcase
            end
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 10'd1;
        // Timeout wins over a handshake landing in the same cycle.
        if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (mem_req_ready) begin
          if (mem_wen_q) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = 32'h0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 10'd1;
        if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (mem_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = rd_ext;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 10'd0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign mem_req_valid = (state_q == REQ);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares them; memory side is driven per access.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  mren = 2'b00;
  logic [1:0]  mwen = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mren(mren), .mwen(mwen), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz,
                                      input logic [1:0] a);
    logic [31:0] v;
    if (sz == 2'b01) begin
      v = (w >> (8 * a)) % 256;
      if (v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b10) begin
      v = (w >> (16 * a[1])) % 65536;
      if (v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_txn(input logic [1:0] mr, input logic [1:0] mw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int dr, input int dv, input logic [31:0] rw);
    exp_t e;
    logic [1:0] sz;
    logic [3:0] strb;
    logic [31:0] wrep;
    bit is_ld, mem_acc, exp_mv;
    int done, n, last_req;
    wait_idle();
    sz = (mr != 2'b00) ? mr : mw;
    is_ld = (mr != 2'b00);
    mem_acc = 0;
    e.acc_cyc = cyc;
    e.rdata = 32'h0;
    e.err = 1'b1;
    e.lat = 1;
    if (mr == 2'b00 && mw == 2'b00) begin
      e.err = 1'b0;
    end else if (mr != 2'b00 && mw != 2'b00) begin
      e.err = 1'b1;
    end else if ((sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00)) begin
      e.err = 1'b1;
    end else begin
      mem_acc = 1;
      done = is_ld ? dr + 1 + dv : dr;
      if (done <= T - 2) begin
        e.err = 1'b0;
        e.lat = done + 2;
        e.rdata = is_ld ? ext(rw, sz, a[1:0]) : 32'h0;
      end else begin
        e.lat = T + 1;
      end
    end
    strb = (sz == 2'b01) ? 4'(1 << a[1:0]) : (sz == 2'b10) ? 4'(3 << a[1:0]) : 4'hF;
    wrep = (sz == 2'b01) ? (wd % 256) * 32'h0101_0101 :
           (sz == 2'b10) ? (wd % 65536) * 32'h0001_0001 : wd;
    req_valid = 1'b1;
    mren = mr;
    mwen = mw;
    addr = a;
    wdata = wd;
    sb_q.push_back(e);
    n = mem_acc ? (is_ld ? dr + 2 + dv : dr + 1) : 1;
    last_req = (dr < T - 1) ? dr : T - 1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mren = 2'($urandom);
      mwen = 2'($urandom);
      addr = $urandom;
      wdata = $urandom;
      mem_req_ready = mem_acc && (c == dr);
      mem_rvalid = mem_acc && is_ld && (c == dr + 1 + dv);
      mem_rdata = mem_rvalid ? rw : $urandom;
      exp_mv = mem_acc && (c <= last_req);
      chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, exp_mv});
      if (exp_mv) begin
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, !is_ld});
        chk("mem_wstrb", {28'd0, mem_wstrb}, is_ld ? 32'd0 : {28'd0, strb});
        if (!is_ld) chk("mem_wdata", mem_wdata, wrep);
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(2'b01, 2'b00, 32'h8000_0003, 32'h0, 0, 0, 32'h8012_3456);
    do_txn(2'b00, 2'b10, 32'h0000_0102, 32'h1234_ABCD, 0, 0, 32'h0);
    do_txn(2'b11, 2'b00, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
    do_txn(2'b00, 2'b11, 32'h0000_0040, 32'hDEAD_BEEF, 10, 0, 32'h0);
    do_txn(2'b11, 2'b00, 32'h0000_0080, 32'h0, 0, 5, 32'h1111_2222);
    do_txn(2'b00, 2'b00, 32'h0000_0010, 32'h5, 0, 0, 32'h0);
    do_txn(2'b10, 2'b01, 32'h0000_0010, 32'h5, 0, 0, 32'h0);
    do_txn(2'b10, 2'b00, 32'h0000_0006, 32'h0, 1, 0, 32'h0000_8001);
    do_txn(2'b00, 2'b01, 32'h0000_0021, 32'h0000_00A5, 2, 0, 32'h0);

    // Reset while waiting for read data, then a late rvalid that must be ignored.
    wait_idle();
    req_valid = 1'b1;
    mren = 2'b11;
    mwen = 2'b00;
    addr = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    do_txn(2'b11, 2'b00, 32'h0000_0204, 32'h0, 0, 0, 32'h7654_3210);

    for (int i = 0; i < 200; i++) begin
      int k;
      logic [1:0] mr, mw;
      k = $urandom_range(0, 7);
      mr = 2'b00;
      mw = 2'b00;
      if (k == 1) begin
        mr = 2'($urandom_range(1, 3));
        mw = 2'($urandom_range(1, 3));
      end else if (k >= 2 && k <= 4) begin
        mr = 2'($urandom_range(1, 3));
      end else if (k >= 5) begin
        mw = 2'($urandom_range(1, 3));
      end
      do_txn(mr, mw, $urandom, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 2), $urandom);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
